life_pattern_loader: RTL and testbench
======================================

LIFE_PATTERN_LOADER -- requirements
Module: life_pattern_loader

Interface
REQ-001 Parameter ROWS, default 4: number of grid rows (>=2).
REQ-002 Parameter COLS, default 4: number of grid columns (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 row_valid  input  1  row_data/row_last valid this cycle.
REQ-006 row_ready  output  1  loader accepts a row this cycle; a transfer occurs when row_valid && row_ready.
REQ-007 row_data  input  COLS  one grid row; bit c = cell (r,c).
REQ-008 row_last  input  1  marks the final row of a frame.
REQ-009 err_clr  input  1  clears err.
REQ-010 load  output  1  one-cycle pulse: data holds a complete new grid for the life core.
REQ-011 data  output  ROWS*COLS  last complete grid; cell (r,c) = bit r*COLS+c; row 0 = LSBs.
REQ-012 busy  output  1  high while a frame is partially assembled (row_cnt != 0) or in LOAD.
REQ-013 err  output  1  sticky framing error.
REQ-014 frames  output  8  count of frames loaded, wraps 255->0.

Function
REQ-015 FSM has two states, COLLECT and LOAD; reset state is COLLECT.
REQ-016 COLLECT: row_ready=1; on a transfer, row_data is written into assembly buffer slice row_cnt*COLS +: COLS.
REQ-017 Transfer with row_cnt<ROWS-1 and row_last=0: row_cnt increments, state stays COLLECT.
REQ-018 Transfer with row_cnt==ROWS-1 and row_last=1: next state LOAD; row_cnt returns to 0.
REQ-019 Framing error: transfer with row_last=1 at row_cnt<ROWS-1, or row_last=0 at row_cnt==ROWS-1 -> err=1 next cycle, frame discarded, row_cnt=0, state stays COLLECT, no load.
REQ-020 LOAD lasts exactly one cycle: row_ready=0, load=1, data shows the new grid in that same cycle; next state COLLECT.
REQ-021 data register updates only on the COLLECT->LOAD transition (assembly buffer copied, including the final row); stable at all other times.
REQ-022 Latency: load is asserted in the cycle immediately after the last-row transfer.
REQ-023 frames increments by 1 in the LOAD cycle (visible the next cycle); 8-bit wrap.
REQ-024 err stays high until err_clr=1 (cleared next cycle); if err_clr and a new framing error occur in the same cycle, err stays 1.
REQ-025 row_valid low: no state change; no transfer during LOAD, so a held row_valid is taken in the next COLLECT cycle.
REQ-026 Maximum throughput: one frame per ROWS+1 cycles.

Reset
REQ-027 rst_n=0 at a clock edge: state=COLLECT, row_cnt=0, assembly buffer=0, data=0, load=0, err=0, frames=0.
REQ-028 Reset mid-frame or during LOAD discards the partial frame; load is 0 in the cycle after the reset edge.
REQ-029 row_ready is 0 while rst_n=0 and 1 in the first cycle after release.

Structure
REQ-030 The shared package holds state encodings (COLLECT, LOAD) and the frame-counter width constant (8).
REQ-031 One sub-module, life_row_counter: clear/enable counter modulo ROWS that flags terminal count; all other logic is in the top.

Verification
REQ-032 ROWS=COLS=4; rows 0x7,0x0,0x0,0x0 back-to-back, last on row 3 -> load pulse 1 cycle after 4th transfer, data=16'h0007, frames=1.
REQ-033 row_last on row 1 of a frame -> err=1, no load, data unchanged; next clean frame rows 0x1,0x2,0x4,0x8 -> data=16'h8421.
REQ-034 row_valid held high for 2 frames -> row_ready=0 exactly in each LOAD cycle; 2 load pulses 5 cycles apart; frames=2.
REQ-035 rst_n=0 after 2 rows accepted -> data=0, busy=0, no load; next full frame loads normally.
REQ-036 Idle gaps (row_valid toggled 1/0) across a frame -> single load; data stable between loads.
REQ-037 256 frames -> frames wraps to 0; err_clr pulse after an error -> err=0 next cycle.

Source files
------------

// File: rtl/life_pattern_loader_pkg.sv
// Shared definitions for the life pattern loader.
//   state_t  : loader FSM encoding (COLLECT assembles rows, LOAD presents a grid)
//   FRAME_W  : width of the loaded-frame counter
package life_pattern_loader_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    LOAD    = 1'b1
  } state_t;

  localparam int FRAME_W = 8;

endpackage

// File: rtl/life_row_counter.sv
// Row counter for frame assembly: counts modulo ROWS and flags the last row.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : return to row 0 (has priority over en)
//   en         : advance by one row
//   cnt        : current row index
//   tc         : high when cnt == ROWS-1
module life_row_counter #(
  parameter int ROWS = 4,
  parameter int CW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/life_pattern_loader.sv
// Assembles a ROWS x COLS life grid from a row stream and hands it to the
// life core with a one-cycle load pulse.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   row_valid/row_ready : row handshake; a row is taken when both are high
//   row_data            : one grid row, bit c = column c
//   row_last            : marks the final row of a frame
//   err_clr             : clears the sticky framing error
//   load                : one-cycle pulse, data holds a fresh grid
//   data                : last complete grid, cell (r,c) at bit r*COLS+c
//   busy                : frame partially assembled or load in progress
//   err                 : sticky framing error
//   frames              : number of grids loaded (wraps)
module life_pattern_loader
  import life_pattern_loader_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [COLS-1:0]      row_data,
  input  logic                 row_last,
  input  logic                 err_clr,
  output logic                 load,
  output logic [ROWS*COLS-1:0] data,
  output logic                 busy,
  output logic                 err,
  output logic [FRAME_W-1:0]   frames
);

  localparam int CW = $clog2(ROWS);

  state_t                state, state_nxt;
  logic                  xfer;
  logic                  good_last;
  logic                  frame_err;
  logic                  tc;
  logic [CW-1:0]         row_cnt;
  logic [ROWS*COLS-1:0]  asm_buf, asm_nxt;

  // row_ready is gated by rst_n so nothing is accepted while reset is held.
  assign row_ready = rst_n && (state == COLLECT);
  assign xfer      = row_valid && row_ready;
  assign good_last = xfer && tc && row_last;
  // row_last must coincide exactly with the last row; any other pairing
  // is a framing error and the frame is dropped.
  assign frame_err = xfer && (row_last != tc);
  assign load      = (state == LOAD);
  assign busy      = (row_cnt != '0) || load;

  life_row_counter #(
    .ROWS (ROWS),
    .CW   (CW)
  ) u_row_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer && (row_last || tc)),
    .en    (xfer),
    .cnt   (row_cnt),
    .tc    (tc)
  );

  always_comb begin
    state_nxt = COLLECT;
    if (state == COLLECT && good_last) begin
      state_nxt = LOAD;
    end
  end

  // asm_nxt already contains the row being accepted, so the final row of a
  // frame reaches data in the same edge that enters LOAD.
  always_comb begin
    asm_nxt = asm_buf;
    for (int r = 0; r < ROWS; r++) begin
      if (xfer && (row_cnt == CW'(r))) begin
        asm_nxt[r*COLS +: COLS] = row_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= COLLECT;
      asm_buf <= '0;
      data    <= '0;
      err     <= 1'b0;
      frames  <= '0;
    end else begin
      state   <= state_nxt;
      asm_buf <= asm_nxt;
      if (good_last) begin
        data <= asm_nxt;
      end
      if (load) begin
        frames <= frames + 1'b1;
      end
      // A new error wins over a simultaneous clear.
      if (frame_err) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_life_pattern_loader.sv
module tb_life_pattern_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            row_valid = 1'b0;
  logic            row_last  = 1'b0;
  logic            err_clr   = 1'b0;
  logic [COLS-1:0] row_data  = '0;
  logic            row_ready;
  logic            load;
  logic            busy;
  logic            err;
  logic [N-1:0]    data;
  logic [7:0]      frames;

  life_pattern_loader #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_last  (row_last),
    .err_clr   (err_clr),
    .load      (load),
    .data      (data),
    .busy      (busy),
    .err       (err),
    .frames    (frames)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [N-1:0] grid;
    logic [7:0]   frames;
  } exp_t;

  exp_t         sb[$];
  int           n_checks   = 0;
  int           n_pass     = 0;
  logic [7:0]   exp_frames = '0;
  logic [N-1:0] model_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every load pulse pops one expected grid; between loads data
  // must hold the last grid that was loaded.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_data = '0;
      end else if (load) begin
        if (sb.size() == 0) begin
          chk("unexpected_load", 32'(load), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("load_data", 32'(data), 32'(e.grid));
          chk("load_frames", 32'(frames), 32'(e.frames));
          model_data = e.grid;
        end
      end else begin
        chk("data_stable", 32'(data), 32'(model_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    row_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_row(input logic [COLS-1:0] d, input logic last);
    int   waited = 0;
    logic took   = 1'b0;
    row_valid = 1'b1;
    row_data  = d;
    row_last  = last;
    do begin
      @(negedge clk);
      took = row_ready;
      tick();
      waited++;
    end while (!took && waited < 20);
    if (!took) chk("row_ready_timeout", 32'(took), 32'd1);
    row_valid = 1'b0;
    row_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] g, input int gap);
    sb.push_back({g, exp_frames});
    for (int r = 0; r < ROWS; r++) begin
      send_row(g[r*COLS +: COLS], (r == ROWS - 1));
      if (gap > 0 && r < ROWS - 1) idle(gap);
    end
    chk("load_latency", 32'(load), 32'd1);
    chk("ready_in_load", 32'(row_ready), 32'd0);
    exp_frames++;
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    row_valid = 1'b0;
    repeat (n) tick();
    chk("rst_ready", 32'(row_ready), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    exp_frames = '0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(row_ready), 32'd1);
  endtask

  initial begin : driver
    int c1;
    do_reset(2);

    // Single frame, back-to-back rows
    send_frame(16'h0007, 0);
    tick();
    chk("frames_one", 32'(frames), 32'd1);

    // row_last on row 1 -> framing error, frame dropped
    send_row(4'h1, 1'b0);
    send_row(4'h2, 1'b1);
    chk("err_set", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_no_load", 32'(load), 32'd0);
    send_frame(16'h8421, 0);
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // New error and clear in the same cycle: error wins
    err_clr = 1'b1;
    send_row(4'h3, 1'b1);
    err_clr = 1'b0;
    chk("err_vs_clr", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", 32'(err), 32'd0);

    // Two frames with row_valid held through the LOAD cycle
    send_frame(16'h1234, 0);
    c1 = cyc;
    send_frame(16'hFEDC, 0);
    chk("load_spacing", 32'(cyc - c1), 32'd5);
    tick();
    chk("frames_four", 32'(frames), 32'd4);

    // Reset after two rows accepted
    send_row(4'hF, 1'b0);
    send_row(4'hF, 1'b0);
    chk("busy_mid", 32'(busy), 32'd1);
    do_reset(1);
    send_frame(16'hA5C3, 0);
    tick();
    chk("frames_after_rst", 32'(frames), 32'd1);

    // Idle gaps between rows
    send_frame(16'h3C96, 1);
    idle(2);
    send_frame(16'h0F01, 2);
    idle(2);

    // 256 frames from reset -> counter wraps to 0
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      send_frame(16'(i * 16'h1357 + 16'h0101), 0);
    end
    tick();
    chk("frames_wrap", 32'(frames), 32'd0);

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
